aes_round_ctrl: RTL and testbench

Control sequencer for the iterative AES-128 encryption datapath. It drives the 128-bit 2:1 state-select mux (sel=0 picks the fresh plaintext path, sel=1 picks the round-output feedback path), the state and round-key register enables, the round counter and the key-expansion round constant. It also marks the final round, where MixColumns is bypassed. Upstream handshakes through start/ready and downstream through out_valid/out_ready; the block holds no 128-bit data itself.

---
 rtl/aes_round_ctrl_if.sv | 46 ++++
 rtl/aes_round_ctrl.sv | 96 +++++++++
 tb/tb_aes_round_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/aes_round_ctrl_if.sv
// Handshake and datapath-control bundle for the AES-128 round sequencer.
// slave = sequencer side, master = datapath/host side.
interface aes_round_ctrl_if;
  logic       start;
  logic       ready;
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic       sel;
  logic       state_en;
  logic       key_en;
  logic       key_sel;
  logic [3:0] round;
  logic [7:0] rcon;
  logic       last_round;

  modport slave (
    input  start,
    input  out_ready,
    output ready,
    output busy,
    output out_valid,
    output sel,
    output state_en,
    output key_en,
    output key_sel,
    output round,
    output rcon,
    output last_round
  );

  modport master (
    output start,
    output out_ready,
    input  ready,
    input  busy,
    input  out_valid,
    input  sel,
    input  state_en,
    input  key_en,
    input  key_sel,
    input  round,
    input  rcon,
    input  last_round
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer: drives state/key muxes and enables,
// round counter and rcon; holds no 128-bit data itself.
module aes_round_ctrl #(
  parameter int NR = 10
) (
  input  logic           clk,
  input  logic           rst,
  aes_round_ctrl_if.slave io
);

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(NR);

  state_t     st;
  logic [3:0] rnd_q;
  logic [7:0] rc_q;
  logic       busy_q;
  logic       ov_q;
  logic       last_q;
  logic       accept;
  logic [3:0] rnd_nx;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  assign io.ready = (st == IDLE) | ((st == DONE) & io.out_ready);
  assign accept   = io.start & io.ready;
  assign rnd_nx   = rnd_q + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= IDLE;
      rnd_q  <= 4'd0;
      rc_q   <= 8'h00;
      busy_q <= 1'b0;
      ov_q   <= 1'b0;
      last_q <= 1'b0;
    end else begin
      unique case (st)
        IDLE, DONE: begin
          if (accept) begin
            st     <= ROUND;
            rnd_q  <= 4'd1;
            rc_q   <= 8'h01;
            busy_q <= 1'b1;
            ov_q   <= 1'b0;
            last_q <= (LAST == 4'd1);
          end else if (st == DONE && io.out_ready) begin
            st   <= IDLE;
            ov_q <= 1'b0;
          end
        end
        ROUND: begin
          if (rnd_q == LAST) begin
            st     <= DONE;
            rnd_q  <= 4'd0;
            rc_q   <= 8'h00;
            busy_q <= 1'b0;
            ov_q   <= 1'b1;
            last_q <= 1'b0;
          end else begin
            rnd_q  <= rnd_nx;
            rc_q   <= xtime(rc_q);
            last_q <= (rnd_nx == LAST);
          end
        end
        default: begin
          st     <= IDLE;
          rnd_q  <= 4'd0;
          rc_q   <= 8'h00;
          busy_q <= 1'b0;
          ov_q   <= 1'b0;
          last_q <= 1'b0;
        end
      endcase
    end
  end

  // Accept-cycle loads are combinational so a DONE->ROUND hop has no bubble.
  assign io.sel        = busy_q;
  assign io.key_sel    = busy_q;
  assign io.state_en   = accept | busy_q;
  assign io.key_en     = accept | busy_q;
  assign io.busy       = busy_q;
  assign io.out_valid  = ov_q;
  assign io.round      = rnd_q;
  assign io.rcon       = rc_q;
  assign io.last_round = last_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl: stimulus pushes expected output
// vectors per cycle, a negedge monitor pops and compares.
module tb_aes_round_ctrl;
  parameter int NR = 10;

  logic clk;
  logic rst;
  aes_round_ctrl_if io();

  aes_round_ctrl #(.NR(NR)) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0] rctab [10];
  initial begin
    rctab[0] = 8'h01; rctab[1] = 8'h02; rctab[2] = 8'h04;
    rctab[3] = 8'h08; rctab[4] = 8'h10; rctab[5] = 8'h20;
    rctab[6] = 8'h40; rctab[7] = 8'h80; rctab[8] = 8'h1b;
    rctab[9] = 8'h36;
  end

  logic [19:0] expq [$];
  string       nameq [$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  // {ready,busy,out_valid,sel,state_en,key_en,key_sel,last,round,rcon}
  function automatic logic [19:0] pk(bit rdy, bit bsy, bit ov, bit sl,
                                     bit se, bit ke, bit ks, bit lr,
                                     logic [3:0] r, logic [7:0] c);
    return {rdy, bsy, ov, sl, se, ke, ks, lr, r, c};
  endfunction

  function automatic logic [19:0] e_idle(bit s);
    return pk(1'b1, 1'b0, 1'b0, 1'b0, s, s, 1'b0, 1'b0, 4'd0, 8'h00);
  endfunction

  function automatic logic [19:0] e_round(int r);
    return pk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, (r == NR),
              4'(r), rctab[r-1]);
  endfunction

  function automatic logic [19:0] e_done(bit s, bit o);
    return pk(o, 1'b0, 1'b1, 1'b0, s & o, s & o, 1'b0, 1'b0,
              4'd0, 8'h00);
  endfunction

  task automatic step(input bit s, input bit o, input bit rs,
                      input logic [19:0] e, input string nm);
    @(posedge clk);
    #1;
    io.start     = s;
    io.out_ready = o;
    rst          = rs;
    expq.push_back(e);
    nameq.push_back(nm);
  endtask

  always @(negedge clk) begin
    logic [19:0] got;
    logic [19:0] e;
    string       nm;
    cyc <= cyc + 1;
    if (expq.size() > 0) begin
      e   = expq.pop_front();
      nm  = nameq.pop_front();
      got = {io.ready, io.busy, io.out_valid, io.sel, io.state_en,
             io.key_en, io.key_sel, io.last_round, io.round, io.rcon};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, e);
      end
    end
  end

  task automatic run_block(input bit hold_start, input int ign_a,
                           input int ign_b);
    for (int r = 1; r <= NR; r++)
      step(hold_start || r == ign_a || r == ign_b, 1'b1, 1'b0,
           e_round(r), "round");
  endtask

  initial begin
    rst          = 1'b1;
    io.start     = 1'b0;
    io.out_ready = 1'b1;

    step(1'b0, 1'b1, 1'b1, e_idle(1'b0), "reset");
    step(1'b0, 1'b1, 1'b0, e_idle(1'b0), "idle");

    // single block
    step(1'b1, 1'b1, 1'b0, e_idle(1'b1), "accept");
    run_block(1'b0, 0, 0);
    step(1'b0, 1'b1, 1'b0, e_done(1'b0, 1'b1), "done");
    step(1'b0, 1'b1, 1'b0, e_idle(1'b0), "post_done");

    // backpressure, including a start ignored while stalled
    step(1'b1, 1'b1, 1'b0, e_idle(1'b1), "bp_accept");
    run_block(1'b0, 0, 0);
    for (int i = 0; i < 5; i++)
      step(i == 2, 1'b0, 1'b0, e_done(i == 2, 1'b0), "bp_hold");
    step(1'b0, 1'b1, 1'b0, e_done(1'b0, 1'b1), "bp_release");
    step(1'b0, 1'b1, 1'b0, e_idle(1'b0), "bp_idle");

    // back-to-back with start held high
    step(1'b1, 1'b1, 1'b0, e_idle(1'b1), "b2b_accept");
    run_block(1'b1, 0, 0);
    step(1'b1, 1'b1, 1'b0, e_done(1'b1, 1'b1), "b2b_done1");
    run_block(1'b1, 0, 0);
    step(1'b1, 1'b1, 1'b0, e_done(1'b1, 1'b1), "b2b_done2");
    run_block(1'b0, 0, 0);
    step(1'b0, 1'b1, 1'b0, e_done(1'b0, 1'b1), "b2b_done3");
    step(1'b0, 1'b1, 1'b0, e_idle(1'b0), "b2b_idle");

    // start pulses while busy are ignored
    step(1'b1, 1'b1, 1'b0, e_idle(1'b1), "ign_accept");
    run_block(1'b0, 3, 7);
    step(1'b0, 1'b1, 1'b0, e_done(1'b0, 1'b1), "ign_done");
    step(1'b0, 1'b1, 1'b0, e_idle(1'b0), "ign_idle");

    // asynchronous reset between edges mid-run
    step(1'b1, 1'b1, 1'b0, e_idle(1'b1), "ar_accept");
    for (int r = 1; r < (NR + 1) / 2; r++)
      step(1'b0, 1'b1, 1'b0, e_round(r), "ar_round");
    @(posedge clk);
    #1;
    io.start = 1'b0;
    expq.push_back(e_idle(1'b0));
    nameq.push_back("async_rst");
    #1 rst = 1'b1;
    step(1'b1, 1'b1, 1'b0, e_idle(1'b1), "ar_restart");
    run_block(1'b0, 0, 0);
    step(1'b0, 1'b1, 1'b0, e_done(1'b0, 1'b1), "ar_done");
    step(1'b0, 1'b1, 1'b0, e_idle(1'b0), "ar_idle");

    for (int i = 0; i < 5 && expq.size() > 0; i++)
      @(posedge clk);
    if (expq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain got=%0d pending exp=0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
